// File: rtl/vid_sdram_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single SDRAM controller port.
// M0 (video fetch) has priority, a burst limit bounds starvation, a tag FIFO steers read beats.
module vid_sdram_arbiter #(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 16,
    parameter int MAX_PEND  = 8,
    parameter int BURST_MAX = 16
) (
    input  logic              iCLOCK,
    input  logic              iRESET,
    input  logic [ADDR_W-1:0] iM0_ADDRESS,
    input  logic              iM0_READ,
    input  logic              iM0_WRITE,
    input  logic [DATA_W-1:0] iM0_WRITE_DATA,
    output logic              oM0_WAIT_REQUEST,
    output logic [DATA_W-1:0] oM0_READ_DATA,
    output logic              oM0_READ_DATA_VALID,
    input  logic [ADDR_W-1:0] iM1_ADDRESS,
    input  logic              iM1_READ,
    input  logic              iM1_WRITE,
    input  logic [DATA_W-1:0] iM1_WRITE_DATA,
    output logic              oM1_WAIT_REQUEST,
    output logic [DATA_W-1:0] oM1_READ_DATA,
    output logic              oM1_READ_DATA_VALID,
    output logic [ADDR_W-1:0] oSDRAM_ADDRESS,
    output logic              oSDRAM_READ,
    output logic              oSDRAM_WRITE,
    output logic [DATA_W-1:0] oSDRAM_WRITE_DATA,
    input  logic              iSDRAM_WAIT_REQUEST,
    input  logic [DATA_W-1:0] iSDRAM_READ_DATA,
    input  logic              iSDRAM_READ_DATA_VALID,
    output logic              oPEND_ERR
);
    localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [PTR_W:0]   PEND_FULL  = (PTR_W + 1)'(MAX_PEND);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_burstCnt;
    logic [MAX_PEND-1:0] r_tags;
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [PTR_W:0]     r_level;
    logic               r_pendErr;

    logic w_req0;
    logic w_req1;
    logic w_ownRead;
    logic w_ownWrite;
    logic w_ownReq;
    logic w_otherReq;
    logic w_ownerId;
    logic w_full;
    logic w_empty;
    logic w_blocked;
    logic w_sdRead;
    logic w_sdWrite;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_headTag;

    assign w_req0    = iM0_READ | iM0_WRITE;
    assign w_req1    = iM1_READ | iM1_WRITE;
    assign w_ownerId = (r_state == LOCK1);
    assign w_full    = (r_level == PEND_FULL);
    assign w_empty   = (r_level == '0);

    // Owner decode and next-state; an illegal read+write pair is treated as a read.
    always_comb begin
        w_ownRead   = 1'b0;
        w_ownWrite  = 1'b0;
        w_ownReq    = 1'b0;
        w_otherReq  = 1'b0;
        w_nextState = r_state;
        case (r_state)
            LOCK0: begin
                w_ownRead  = iM0_READ;
                w_ownWrite = iM0_WRITE & ~iM0_READ;
                w_ownReq   = w_req0;
                w_otherReq = w_req1;
            end
            LOCK1: begin
                w_ownRead  = iM1_READ;
                w_ownWrite = iM1_WRITE & ~iM1_READ;
                w_ownReq   = w_req1;
                w_otherReq = w_req0;
            end
            default: ;
        endcase
        case (r_state)
            IDLE: begin
                if (w_req0) begin
                    w_nextState = LOCK0;
                end else if (w_req1) begin
                    w_nextState = LOCK1;
                end
            end
            LOCK0, LOCK1: begin
                if (!w_ownReq) begin
                    w_nextState = w_otherReq ? ((r_state == LOCK0) ? LOCK1 : LOCK0) : IDLE;
                end else if (w_accept && w_otherReq && (r_burstCnt == BURST_LAST)) begin
                    w_nextState = (r_state == LOCK0) ? LOCK1 : LOCK0;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_blocked = w_ownRead & w_full;
    assign w_sdRead  = w_ownRead & ~w_full;
    assign w_sdWrite = w_ownWrite;
    assign w_accept  = (w_sdRead | w_sdWrite) & ~iSDRAM_WAIT_REQUEST;
    assign w_push    = w_accept & w_sdRead;
    assign w_pop     = iSDRAM_READ_DATA_VALID & ~w_empty;
    assign w_headTag = r_tags[r_rdPtr];

    assign oSDRAM_ADDRESS    = (r_state == LOCK1) ? iM1_ADDRESS : iM0_ADDRESS;
    assign oSDRAM_WRITE_DATA = (r_state == LOCK1) ? iM1_WRITE_DATA : iM0_WRITE_DATA;
    assign oSDRAM_READ       = w_sdRead;
    assign oSDRAM_WRITE      = w_sdWrite;

    assign oM0_WAIT_REQUEST    = (r_state != LOCK0) | iSDRAM_WAIT_REQUEST | w_blocked;
    assign oM1_WAIT_REQUEST    = (r_state != LOCK1) | iSDRAM_WAIT_REQUEST | w_blocked;
    assign oM0_READ_DATA       = iSDRAM_READ_DATA;
    assign oM1_READ_DATA       = iSDRAM_READ_DATA;
    assign oM0_READ_DATA_VALID = w_pop & ~w_headTag;
    assign oM1_READ_DATA_VALID = w_pop & w_headTag;
    assign oPEND_ERR           = r_pendErr;

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The burst counter only advances while the other master is actually waiting.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            r_burstCnt <= '0;
        end else if (w_nextState != r_state) begin
            r_burstCnt <= '0;
        end else if (w_accept && w_otherReq) begin
            r_burstCnt <= r_burstCnt + 1'b1;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            r_tags  <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_tags[r_wrPtr] <= w_ownerId;
                r_wrPtr         <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            r_pendErr <= 1'b0;
        end else if (iSDRAM_READ_DATA_VALID && w_empty) begin
            r_pendErr <= 1'b1;
        end
    end
endmodule
